// File: rtl/gpio_wr_arb_pkg.sv
// Shared types for the GPIO register write arbiter: write-op encoding,
// arbiter FSM states, the default requester count and small op decoders.
package gpio_wr_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;

  // Bit 0 selects a masked (split 16-bit) write, bit 1 selects the OE register.
  typedef enum logic [1:0] {
    OP_DIR_OUT = 2'd0,
    OP_MSK_OUT = 2'd1,
    OP_DIR_OE  = 2'd2,
    OP_MSK_OE  = 2'd3
  } gpio_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE_DIR = 2'd1,
    ST_ISSUE_UP  = 2'd2,
    ST_ISSUE_LO  = 2'd3
  } arb_state_e;

  function automatic logic op_is_masked(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_oe(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester at or
// after the pointer (wrapping) as a one-hot grant plus its index.
module gpio_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [2:0]         idx_o,
  output logic               any_o
);

  logic [7:0] valid_ext;
  logic [3:0] cand;
  logic       found;

  assign valid_ext = 8'(valid_i);

  // Walk the requesters starting at the pointer and latch the first hit.
  always_comb begin
    idx_o = 3'd0;
    found = 1'b0;
    cand  = 4'd0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = {1'b0, ptr_i} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!found && valid_ext[cand[2:0]]) begin
        found = 1'b1;
        idx_o = cand[2:0];
      end
    end
  end

  // Expand the chosen index into a one-hot grant vector.
  always_comb begin
    grant_o = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      grant_o[j] = found && (idx_o == 3'(j));
    end
  end

  assign any_o = found;

endmodule

// File: rtl/gpio_wr_arb.sv
// GPIO register write arbiter: several requesters share one write port into
// the GPIO direct / masked OUT and OE registers. A request is accepted only
// when idle; masked writes are split into upper and lower 16-bit strobes.
// Optional build macro GPIO_WR_ARB_LOCK_EN lets a requester hold the grant.
module gpio_wr_arb
  import gpio_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [2*NUM_REQ-1:0]    req_op_i,
  input  logic [32*NUM_REQ-1:0]   req_data_i,
  input  logic [32*NUM_REQ-1:0]   req_mask_i,
  input  logic [NUM_REQ-1:0]      req_lock_i,
  output logic [31:0]             direct_out_q,
  output logic                    direct_out_qe,
  output logic [31:0]             direct_oe_q,
  output logic                    direct_oe_qe,
  output logic [15:0]             masked_out_upper_data_q,
  output logic [15:0]             masked_out_upper_mask_q,
  output logic                    masked_out_upper_qe,
  output logic [15:0]             masked_out_lower_data_q,
  output logic [15:0]             masked_out_lower_mask_q,
  output logic                    masked_out_lower_qe,
  output logic [15:0]             masked_oe_upper_data_q,
  output logic [15:0]             masked_oe_upper_mask_q,
  output logic                    masked_oe_upper_qe,
  output logic [15:0]             masked_oe_lower_data_q,
  output logic [15:0]             masked_oe_lower_mask_q,
  output logic                    masked_oe_lower_qe,
  output logic                    busy_o,
  output logic [2:0]              grant_idx_o
);

  arb_state_e state_q, state_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  gpio_op_e   cap_op_q, cap_op_d;
  logic [31:0] cap_data_q, cap_data_d;
  logic [31:0] cap_mask_q, cap_mask_d;

  logic [NUM_REQ-1:0] pick_valid;
  logic [NUM_REQ-1:0] pick_grant;
  logic [2:0]         pick_idx;
  logic               pick_any;
  logic [1:0]         sel_op;
  logic [31:0]        sel_data;
  logic [31:0]        sel_mask;
  logic               accept;
  logic               accept_lock;
  logic [2:0]         ptr_after;
  logic               cap_is_oe;

`ifdef GPIO_WR_ARB_LOCK_EN
  logic [7:0] lock_ext;
  logic       lock_q, lock_d;
  logic       lock_hold;

  assign lock_ext    = 8'(req_lock_i);
  assign lock_hold   = lock_q && lock_ext[rr_ptr_q];
  assign accept_lock = |(req_lock_i & pick_grant);

  // While the lock owner keeps its lock raised, hide everyone else from the picker.
  always_comb begin
    pick_valid = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      pick_valid[j] = req_valid_i[j] && (!lock_hold || (rr_ptr_q == 3'(j)));
    end
  end

  // The lock drops as soon as the owner lowers req_lock_i; a new accept may re-arm it.
  always_comb begin
    lock_d = lock_hold;
    if (accept) begin
      lock_d = accept_lock;
    end
  end

  // Lock flag register; the owner index is rr_ptr_q, which stays parked on it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^req_lock_i;
  assign accept_lock = 1'b0;
  assign pick_valid  = req_valid_i;
`endif

  gpio_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Mux out the op, data and mask of the requester the picker chose.
  always_comb begin
    sel_op   = 2'd0;
    sel_data = 32'd0;
    sel_mask = 32'd0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_grant[i]) begin
        sel_op   = req_op_i[2*i +: 2];
        sel_data = req_data_i[32*i +: 32];
        sel_mask = req_mask_i[32*i +: 32];
      end
    end
  end

  assign ptr_after = (pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick_idx + 3'd1;

  // Next-state logic: accept in IDLE, then walk through the strobe states.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    cap_op_d    = cap_op_q;
    cap_data_d  = cap_data_q;
    cap_mask_d  = cap_mask_q;
    accept      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          accept      = 1'b1;
          grant_idx_d = pick_idx;
          rr_ptr_d    = accept_lock ? pick_idx : ptr_after;
          cap_op_d    = gpio_op_e'(sel_op);
          cap_data_d  = sel_data;
          cap_mask_d  = sel_mask;
          if (!op_is_masked(sel_op)) begin
            state_d = ST_ISSUE_DIR;
          end else if (|sel_mask[31:16]) begin
            state_d = ST_ISSUE_UP;
          end else if (|sel_mask[15:0]) begin
            state_d = ST_ISSUE_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ISSUE_DIR: begin
        state_d = ST_IDLE;
      end
      ST_ISSUE_UP: begin
        state_d = (|cap_mask_q[15:0]) ? ST_ISSUE_LO : ST_IDLE;
      end
      ST_ISSUE_LO: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer and captured-request registers; reset discards any in-flight op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 3'd0;
      grant_idx_q <= 3'd0;
      cap_op_q    <= OP_DIR_OUT;
      cap_data_q  <= 32'd0;
      cap_mask_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      cap_op_q    <= cap_op_d;
      cap_data_q  <= cap_data_d;
      cap_mask_q  <= cap_mask_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) ? pick_grant : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign grant_idx_o = grant_idx_q;
  assign cap_is_oe   = op_is_oe(cap_op_q);

  assign direct_out_qe       = (state_q == ST_ISSUE_DIR) && !cap_is_oe;
  assign direct_oe_qe        = (state_q == ST_ISSUE_DIR) &&  cap_is_oe;
  assign masked_out_upper_qe = (state_q == ST_ISSUE_UP)  && !cap_is_oe;
  assign masked_out_lower_qe = (state_q == ST_ISSUE_LO)  && !cap_is_oe;
  assign masked_oe_upper_qe  = (state_q == ST_ISSUE_UP)  &&  cap_is_oe;
  assign masked_oe_lower_qe  = (state_q == ST_ISSUE_LO)  &&  cap_is_oe;

  assign direct_out_q            = cap_data_q;
  assign direct_oe_q             = cap_data_q;
  assign masked_out_upper_data_q = cap_data_q[31:16];
  assign masked_out_upper_mask_q = cap_mask_q[31:16];
  assign masked_out_lower_data_q = cap_data_q[15:0];
  assign masked_out_lower_mask_q = cap_mask_q[15:0];
  assign masked_oe_upper_data_q  = cap_data_q[31:16];
  assign masked_oe_upper_mask_q  = cap_mask_q[31:16];
  assign masked_oe_lower_data_q  = cap_data_q[15:0];
  assign masked_oe_lower_mask_q  = cap_mask_q[15:0];

endmodule

// File: tb/tb_gpio_wr_arb.sv
// Testbench for gpio_wr_arb: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_gpio_wr_arb;
  import gpio_wr_arb_pkg::*;

  localparam int N = 4;
`ifdef GPIO_WR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [2*N-1:0]    req_op_i;
  logic [32*N-1:0]   req_data_i;
  logic [32*N-1:0]   req_mask_i;
  logic [N-1:0]      req_lock_i;
  logic [31:0]       direct_out_q, direct_oe_q;
  logic              direct_out_qe, direct_oe_qe;
  logic [15:0]       masked_out_upper_data_q, masked_out_upper_mask_q;
  logic [15:0]       masked_out_lower_data_q, masked_out_lower_mask_q;
  logic [15:0]       masked_oe_upper_data_q, masked_oe_upper_mask_q;
  logic [15:0]       masked_oe_lower_data_q, masked_oe_lower_mask_q;
  logic              masked_out_upper_qe, masked_out_lower_qe;
  logic              masked_oe_upper_qe, masked_oe_lower_qe;
  logic              busy_o;
  logic [2:0]        grant_idx_o;
  logic [5:0]        qe_vec;

  int checks = 0;
  int errors = 0;

  // Expected strobe: one-hot qe in qe_vec order, plus the value it should carry.
  typedef struct packed {
    logic [5:0]  qe;
    logic [31:0] val;
  } strobe_t;

  strobe_t pend[$];

  always #5 clk_i = ~clk_i;

  assign qe_vec = {direct_out_qe, direct_oe_qe, masked_out_upper_qe,
                   masked_out_lower_qe, masked_oe_upper_qe, masked_oe_lower_qe};

  gpio_wr_arb #(
    .NUM_REQ (N)
  ) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .req_valid_i             (req_valid_i),
    .req_ready_o             (req_ready_o),
    .req_op_i                (req_op_i),
    .req_data_i              (req_data_i),
    .req_mask_i              (req_mask_i),
    .req_lock_i              (req_lock_i),
    .direct_out_q            (direct_out_q),
    .direct_out_qe           (direct_out_qe),
    .direct_oe_q             (direct_oe_q),
    .direct_oe_qe            (direct_oe_qe),
    .masked_out_upper_data_q (masked_out_upper_data_q),
    .masked_out_upper_mask_q (masked_out_upper_mask_q),
    .masked_out_upper_qe     (masked_out_upper_qe),
    .masked_out_lower_data_q (masked_out_lower_data_q),
    .masked_out_lower_mask_q (masked_out_lower_mask_q),
    .masked_out_lower_qe     (masked_out_lower_qe),
    .masked_oe_upper_data_q  (masked_oe_upper_data_q),
    .masked_oe_upper_mask_q  (masked_oe_upper_mask_q),
    .masked_oe_upper_qe      (masked_oe_upper_qe),
    .masked_oe_lower_data_q  (masked_oe_lower_data_q),
    .masked_oe_lower_mask_q  (masked_oe_lower_mask_q),
    .masked_oe_lower_qe      (masked_oe_lower_qe),
    .busy_o                  (busy_o),
    .grant_idx_o             (grant_idx_o)
  );

  task automatic clear_inputs();
    req_valid_i = '0;
    req_op_i    = '0;
    req_data_i  = '0;
    req_mask_i  = '0;
    req_lock_i  = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] d,
                         input logic [31:0] m, input logic lk);
    req_valid_i[i]        = 1'b1;
    req_op_i[2*i +: 2]    = op;
    req_data_i[32*i +: 32] = d;
    req_mask_i[32*i +: 32] = m;
    req_lock_i[i]         = lk;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    #3;
    checks++;
    if (qe_vec !== 6'b0 || busy_o !== 1'b0 || grant_idx_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got qe=%b busy=%b gidx=%0d expected qe=0 busy=0 gidx=0",
               qe_vec, busy_o, grant_idx_o);
    end
    checks++;
    if (direct_out_q !== 32'h0 || {masked_out_upper_data_q, masked_oe_lower_mask_q} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h/%h%h expected 0", direct_out_q,
               masked_out_upper_data_q, masked_oe_lower_mask_q);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_direct();
    @(negedge clk_i);
    clear_inputs();
    set_req(0, OP_DIR_OUT, 32'hA5A5_0001, 32'h0, 1'b0);
    #1;
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL direct_ready: got %b expected 0001", req_ready_o);
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++;
    if (qe_vec !== 6'b100000 || direct_out_q !== 32'hA5A5_0001 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL direct_strobe: got qe=%b data=%h busy=%b expected qe=100000 data=a5a50001 busy=1",
               qe_vec, direct_out_q, busy_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (qe_vec !== 6'b0 || busy_o !== 1'b0 || grant_idx_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL direct_done: got qe=%b busy=%b gidx=%0d expected 0/0/0",
               qe_vec, busy_o, grant_idx_o);
    end
  endtask

  task automatic test_masked_split();
    @(negedge clk_i);
    clear_inputs();
    set_req(1, OP_MSK_OUT, 32'h1234_5678, 32'hFF00_00FF, 1'b0);
    #1;
    checks++;
    if (req_ready_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL split_ready: got %b expected 0010", req_ready_o);
    end
    @(negedge clk_i);
    clear_inputs();
    set_req(0, OP_DIR_OUT, 32'h0BAD_0BAD, 32'h0, 1'b0);
    #1;
    checks++;
    if (qe_vec !== 6'b001000 || {masked_out_upper_data_q, masked_out_upper_mask_q} !== 32'h1234_FF00
        || req_ready_o !== 4'b0) begin
      errors++;
      $display("[TB] FAIL split_upper: got qe=%b d/m=%h%h rdy=%b expected 001000 1234ff00 0000",
               qe_vec, masked_out_upper_data_q, masked_out_upper_mask_q, req_ready_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (qe_vec !== 6'b000100 || {masked_out_lower_data_q, masked_out_lower_mask_q} !== 32'h5678_00FF
        || req_ready_o !== 4'b0) begin
      errors++;
      $display("[TB] FAIL split_lower: got qe=%b d/m=%h%h rdy=%b expected 000100 567800ff 0000",
               qe_vec, masked_out_lower_data_q, masked_out_lower_mask_q, req_ready_o);
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++;
    if (qe_vec !== 6'b0 || busy_o !== 1'b0 || grant_idx_o !== 3'd1) begin
      errors++;
      $display("[TB] FAIL split_done: got qe=%b busy=%b gidx=%0d expected 0/0/1",
               qe_vec, busy_o, grant_idx_o);
    end
  endtask

  task automatic test_masked_zero();
    @(negedge clk_i);
    clear_inputs();
    set_req(2, OP_MSK_OE, 32'hFFFF_FFFF, 32'h0, 1'b0);
    #1;
    checks++;
    if (req_ready_o !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL zero_ready: got %b expected 0100", req_ready_o);
    end
    @(negedge clk_i);
    clear_inputs();
    set_req(3, OP_DIR_OUT, 32'h0000_0033, 32'h0, 1'b0);
    #1;
    checks++;
    if (qe_vec !== 6'b0 || busy_o !== 1'b0 || req_ready_o !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL zero_nostrobe: got qe=%b busy=%b rdy=%b expected 0/0/1000",
               qe_vec, busy_o, req_ready_o);
    end
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++;
    if (qe_vec !== 6'b100000 || direct_out_q !== 32'h0000_0033) begin
      errors++;
      $display("[TB] FAIL zero_follow: got qe=%b data=%h expected 100000 00000033", qe_vec, direct_out_q);
    end
    @(negedge clk_i);
  endtask

  task automatic test_round_robin();
    int got[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int g;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk_i);
      for (int i = 0; i < N; i++) set_req(i, OP_DIR_OE, 32'h0000_1000 + i, 32'h0, 1'b0);
      #1;
      checks++;
      if ($countones(req_ready_o) > 1) begin
        errors++;
        $display("[TB] FAIL rr_onehot: got %b expected at most one bit", req_ready_o);
      end
      for (int i = 0; i < N; i++) if (req_ready_o[i]) got.push_back(i);
    end
    @(negedge clk_i);
    clear_inputs();
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d grants expected 5", got.size());
    end
    for (int k = 0; k < 5; k++) begin
      g = (k < got.size()) ? got[k] : -1;
      checks++;
      if (g != exp_order[k]) begin
        errors++;
        $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", k, g, exp_order[k]);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_midop();
    @(negedge clk_i);
    clear_inputs();
    set_req(1, OP_MSK_OUT, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk_i);
    clear_inputs();
    #1;
    checks++;
    if (qe_vec !== 6'b001000) begin
      errors++;
      $display("[TB] FAIL midop_upper: got qe=%b expected 001000", qe_vec);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (qe_vec !== 6'b0 || busy_o !== 1'b0 || grant_idx_o !== 3'd0 || direct_out_q !== 32'h0
        || {masked_out_upper_data_q, masked_out_upper_mask_q} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got qe=%b busy=%b gidx=%0d d=%h u=%h%h expected all zero",
               qe_vec, busy_o, grant_idx_o, direct_out_q, masked_out_upper_data_q, masked_out_upper_mask_q);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (qe_vec !== 6'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midop_quiet[%0d]: got qe=%b busy=%b expected 0/0", cyc, qe_vec, busy_o);
      end
    end
  endtask

  task automatic test_lock();
    int exp_g[4];
    int g;
    if (LOCK_EN) exp_g = '{3, 3, 3, 0};
    else         exp_g = '{3, 0, 1, 2};
    @(negedge clk_i);
    clear_inputs();
    set_req(2, OP_DIR_OUT, 32'h2, 32'h0, 1'b0);
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      clear_inputs();
      for (int i = 0; i < 3; i++) set_req(i, OP_DIR_OUT, 32'h100 + i, 32'h0, 1'b0);
      if (cyc < 6) set_req(3, OP_DIR_OUT, 32'h103, 32'h0, 1'b1);
      #1;
      g = -1;
      for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
      checks++;
      if (cyc % 2 == 0) begin
        if (g != exp_g[cyc/2]) begin
          errors++;
          $display("[TB] FAIL lock_grant[%0d]: got %0d expected %0d", cyc, g, exp_g[cyc/2]);
        end
      end else if (g != -1) begin
        errors++;
        $display("[TB] FAIL lock_busy[%0d]: got grant %0d expected none", cyc, g);
      end
    end
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_random();
    strobe_t      exp_s;
    int           m_ptr, m_owner, m_gidx, g, cand;
    bit           busy;
    logic [N-1:0] elig, exp_ready;
    logic [1:0]   op;
    logic [31:0]  d, m, obs;
    pend.delete();
    m_ptr = 0; m_owner = -1; m_gidx = 0;
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_i);
      for (int i = 0; i < N; i++) begin
        op = 2'($urandom_range(0, 3));
        d  = $urandom;
        case ($urandom_range(0, 3))
          0:       m = 32'h0;
          1:       m = {16'h0, 16'($urandom_range(1, 65535))};
          2:       m = {16'($urandom_range(1, 65535)), 16'h0};
          default: m = $urandom;
        endcase
        req_valid_i[i]         = ($urandom_range(0, 2) != 0);
        req_op_i[2*i +: 2]     = op;
        req_data_i[32*i +: 32] = d;
        req_mask_i[32*i +: 32] = m;
        req_lock_i[i]          = ($urandom_range(0, 3) == 0);
      end
      #1;
      busy  = (pend.size() != 0);
      exp_s = busy ? pend[0] : '0;
      elig  = req_valid_i;
      if (LOCK_EN && m_owner >= 0 && req_lock_i[m_owner]) elig = req_valid_i & (N'(1) << m_owner);
      g = -1;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          cand = (m_ptr + k) % N;
          if (g < 0 && elig[cand]) g = cand;
        end
      end
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      checks++;
      if (req_ready_o !== exp_ready || qe_vec !== exp_s.qe || busy_o !== busy
          || grant_idx_o !== 3'(m_gidx)) begin
        errors++;
        $display("[TB] FAIL rand_ctrl[%0d]: got rdy=%b qe=%b busy=%b gidx=%0d expected rdy=%b qe=%b busy=%b gidx=%0d",
                 cyc, req_ready_o, qe_vec, busy_o, grant_idx_o, exp_ready, exp_s.qe, busy, m_gidx);
      end
      if (busy) begin
        if      (exp_s.qe[5]) obs = direct_out_q;
        else if (exp_s.qe[4]) obs = direct_oe_q;
        else if (exp_s.qe[3]) obs = {masked_out_upper_data_q, masked_out_upper_mask_q};
        else if (exp_s.qe[2]) obs = {masked_out_lower_data_q, masked_out_lower_mask_q};
        else if (exp_s.qe[1]) obs = {masked_oe_upper_data_q, masked_oe_upper_mask_q};
        else                  obs = {masked_oe_lower_data_q, masked_oe_lower_mask_q};
        checks++;
        if (obs !== exp_s.val) begin
          errors++;
          $display("[TB] FAIL rand_data[%0d]: got %h expected %h (qe=%b)", cyc, obs, exp_s.val, exp_s.qe);
        end
        void'(pend.pop_front());
      end
      if (LOCK_EN && m_owner >= 0 && !req_lock_i[m_owner]) m_owner = -1;
      if (g >= 0) begin
        m_gidx = g;
        m_ptr  = (g + 1) % N;
        if (LOCK_EN && req_lock_i[g]) begin
          m_owner = g;
          m_ptr   = g;
        end
        op = req_op_i[2*g +: 2];
        d  = req_data_i[32*g +: 32];
        m  = req_mask_i[32*g +: 32];
        case (op)
          2'd0: pend.push_back('{6'b100000, d});
          2'd2: pend.push_back('{6'b010000, d});
          2'd1: begin
            if (m[31:16] != 16'h0) pend.push_back('{6'b001000, {d[31:16], m[31:16]}});
            if (m[15:0]  != 16'h0) pend.push_back('{6'b000100, {d[15:0],  m[15:0]}});
          end
          default: begin
            if (m[31:16] != 16'h0) pend.push_back('{6'b000010, {d[31:16], m[31:16]}});
            if (m[15:0]  != 16'h0) pend.push_back('{6'b000001, {d[15:0],  m[15:0]}});
          end
        endcase
      end
    end
    @(negedge clk_i);
    clear_inputs();
    repeat (3) @(negedge clk_i);
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_direct();
    test_masked_split();
    test_masked_zero();
    test_round_robin();
    test_reset_midop();
    test_lock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_wr_arb.md
GPIO_WR_ARB -- requirements
Module: gpio_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4 (range 2..8): number of requesters sharing the GPIO register write port.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 req_valid_i  input  NUM_REQ  per-requester write request.
REQ-005 req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-006 req_op_i  input  2*NUM_REQ  per-requester op, 2 bits each: 0 DIR_OUT, 1 MSK_OUT, 2 DIR_OE, 3 MSK_OE.
REQ-007 req_data_i  input  32*NUM_REQ  per-requester write data.
REQ-008 req_mask_i  input  32*NUM_REQ  per-requester bit mask; masked ops only.
REQ-009 req_lock_i  input  NUM_REQ  per-requester grant-lock request.
REQ-010 direct_out_q / direct_oe_q  output  32 each  direct write data; direct_out_qe / direct_oe_qe  output  1 each  single-cycle strobes.
REQ-011 masked_{out,oe}_{upper,lower}_data_q / _mask_q  output  16 each; matching _qe  output  1 each  single-cycle strobes.
REQ-012 busy_o  output  1  high in any non-IDLE state; grant_idx_o  output  3  index of the last accepted requester.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE_DIR, ISSUE_UP, ISSUE_LO.
REQ-014 In IDLE with any valid, the round-robin picker SHALL select the first valid requester at or after pointer rr_ptr (wrapping), raise its req_ready_o combinationally, and capture op/data/mask.
REQ-015 req_ready_o SHALL be all-zero outside IDLE; requests SHALL only be accepted in IDLE.
REQ-016 On accept, rr_ptr SHALL become (granted index + 1) mod NUM_REQ and grant_idx_o SHALL load the granted index.
REQ-017 After accepting a direct op, the FSM SHALL go to ISSUE_DIR; that state SHALL assert exactly one of direct_out_qe/direct_oe_qe for one cycle with captured data, then return to IDLE.
REQ-018 After accepting a masked op, the FSM SHALL go to ISSUE_UP if mask[31:16] != 0, else to ISSUE_LO if mask[15:0] != 0, else back to IDLE with no strobe.
REQ-019 ISSUE_UP SHALL pulse the selected upper _qe with data[31:16]/mask[31:16], then go to ISSUE_LO if mask[15:0] != 0, else to IDLE.
REQ-020 ISSUE_LO SHALL pulse the selected lower _qe with data[15:0]/mask[15:0], then go to IDLE.
REQ-021 No two _qe outputs SHALL be high in the same cycle; all outputs SHALL decode from registers only, with no input-to-output path except req_ready_o.
REQ-022 Latency: accept in cycle N; first strobe in N+1; second masked strobe (if any) in N+2; next accept no earlier than N+2 (direct) or N+3 (split masked).
REQ-023 Data/mask outputs SHALL hold captured values while idle and SHALL be zero after reset.

Reset
REQ-024 Asserting rst_ni low SHALL, asynchronously, force IDLE, rr_ptr=0, grant_idx_o=0, all _qe=0, all data/mask=0, busy_o=0, and discard any in-flight op with no further strobe.

Configuration
REQ-025 With GPIO_WR_ARB_LOCK_EN defined, if the accepted requester's req_lock_i is high at accept, rr_ptr SHALL stay at that requester.
REQ-026 With GPIO_WR_ARB_LOCK_EN defined, only that requester SHALL be granted until its req_lock_i goes low; the lock SHALL be released on that cycle.
REQ-027 Without GPIO_WR_ARB_LOCK_EN, req_lock_i SHALL remain a port and be ignored.

Structure
REQ-028 Package gpio_wr_arb_pkg SHALL hold the op enum, the FSM state enum, and the NUM_REQ default.
REQ-029 Sub-module gpio_rr_pick SHALL implement the combinational round-robin selection (valid vector, pointer -> one-hot grant plus index).

Verification
REQ-030 Req0 DIR_OUT data 0xA5A5_0001 -> ready[0] in cycle N; direct_out_qe=1 with 0xA5A5_0001 in N+1 only; busy_o=0 in N+2.
REQ-031 Req1 MSK_OUT data 0x1234_5678 mask 0xFF00_00FF -> upper qe with data 0x1234/mask 0xFF00 in N+1; lower qe with 0x5678/0x00FF in N+2.
REQ-032 Req2 MSK_OE mask 0x0000_0000 -> accepted; no strobe; IDLE in N+1.
REQ-033 All four requesters valid continuously with DIR_OE -> grants in order 0,1,2,3,0; never two ready bits in one cycle.
REQ-034 rst_ni low during ISSUE_UP of a split masked op -> all outputs zero immediately; no lower strobe after release.
REQ-035 GPIO_WR_ARB_LOCK_EN defined, req3 lock high with req0..2 valid -> only req3 granted until lock low, then req0 is granted next.
